// File: rtl/spi_req_arbiter_pkg.sv
// Shared definitions for the SPI request arbiter: FSM encoding, widths and the
// SPI word size shared with the serial master.
package spi_req_arbiter_pkg;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

  localparam int SPI_BITS = 4;
  localparam int MAX_NREQ = 8;
  localparam int GRANT_W  = clog2(MAX_NREQ);
  localparam int TIMER_W  = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    START     = 3'd2,
    WAIT_DONE = 3'd3,
    ACK       = 3'd4,
    ERR       = 3'd5
  } state_t;

endpackage

// File: rtl/spi_req_arbiter_rr_pick.sv
// Combinational round-robin picker: lowest asserted request at or above Ptr,
// otherwise the lowest asserted request overall (wrap-around).
module rr_pick
  import spi_req_arbiter_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]    Req,
  input  logic [GRANT_W-1:0] Ptr,
  output logic               Valid,
  output logic [GRANT_W-1:0] Idx
);

  logic               hi_valid;
  logic [GRANT_W-1:0] hi_idx;
  logic [GRANT_W-1:0] lo_idx;

  // NOTE: every signal assigned in always_comb gets a default first so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    hi_valid = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    Valid    = 1'b0;
    // Descending scan so the lowest matching index is the last one written.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (Req[i]) begin
        Valid  = 1'b1;
        lo_idx = GRANT_W'(i);
        if (GRANT_W'(i) >= Ptr) begin
          hi_valid = 1'b1;
          hi_idx   = GRANT_W'(i);
        end
      end
    end
    Idx = hi_valid ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter sharing one output-only SPI master among NREQ requesters;
// latches the granted word, starts the master and acknowledges or aborts.
module spi_req_arbiter
  import spi_req_arbiter_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int BITS    = SPI_BITS,
  parameter int TIMEOUT = 64
) (
  input  logic                 Clock,
  input  logic                 ResetN,
  input  logic [NREQ-1:0]      Req,
  input  logic [NREQ*BITS-1:0] ReqData,
  output logic [NREQ-1:0]      Ack,
  output logic                 Err,
  output logic                 Busy,
  output logic [GRANT_W-1:0]   GrantId,
  output logic                 MStart,
  output logic [BITS-1:0]      MData,
  input  logic                 MIdle,
  input  logic                 MDone
);

  state_t               state;
  logic [GRANT_W-1:0]   ptr;
  logic [TIMER_W-1:0]   timer;
  logic                 pick_valid;
  logic [GRANT_W-1:0]   pick_idx;
  logic [BITS-1:0]      pick_data;
  logic [NREQ-1:0]      grant_onehot;
  logic [GRANT_W-1:0]   next_ptr;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .Req   (Req),
    .Ptr   (ptr),
    .Valid (pick_valid),
    .Idx   (pick_idx)
  );

  always_comb begin
    pick_data    = '0;
    grant_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == GRANT_W'(i)) pick_data = ReqData[i*BITS +: BITS];
      if (GrantId == GRANT_W'(i))  grant_onehot[i] = 1'b1;
    end
    next_ptr = (GrantId == GRANT_W'(NREQ - 1)) ? '0 : GrantId + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state   <= IDLE;
      Ack     <= '0;
      Err     <= 1'b0;
      Busy    <= 1'b0;
      GrantId <= '0;
      MStart  <= 1'b0;
      MData   <= '0;
      ptr     <= '0;
      timer   <= '0;
    end else begin
      // Ack, Err and MStart are single-cycle pulses unless re-armed below.
      Ack    <= '0;
      Err    <= 1'b0;
      MStart <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            GrantId <= pick_idx;
            MData   <= pick_data;
            Busy    <= 1'b1;
            timer   <= '0;
            state   <= LOAD;
          end
        end
        LOAD: begin
          if (MIdle) begin
            MStart <= 1'b1;
            timer  <= '0;
            state  <= START;
          end else if (timer != '1) begin
            timer <= timer + 1'b1;
          end
        end
        START: begin
          timer <= '0;
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          // A done arriving in the timeout cycle still completes the transfer.
          if (MDone) begin
            Ack   <= grant_onehot;
            state <= ACK;
          end else if (timer == TIMER_W'(TIMEOUT - 1)) begin
            Err   <= 1'b1;
            state <= ERR;
          end else if (timer != '1) begin
            timer <= timer + 1'b1;
          end
        end
        ACK, ERR: begin
          ptr   <= next_ptr;
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
